// File: rtl/moving_average_fir.sv
// Purpose : boxcar (moving-average) FIR over the last TAPS unsigned samples, with raw-sample bypass.
// Latency : one cycle; out_valid pulses in the cycle after each accepted sample.
// Backpres: none; one sample per clock accepted unconditionally (clear drops a coincident sample).
//
// Ports
//   CLOCK_50  : single clock, all state updates on its rising edge
//   reset_n   : synchronous active-low reset, overrides everything
//   clear     : synchronous flush of history/sum/fill state; out_data holds
//   mode      : 0 = moving average, 1 = bypass (raw sample out), sampled with the sample
//   in_valid  : in_data carries a new sample this cycle
//   in_data   : unsigned sample, DATA_W bits
//   out_valid : one-cycle pulse, out_data carries a new result
//   out_data  : registered result, holds its value between pulses
//   primed    : high once TAPS samples have been accepted since reset/clear
module moving_average_fir #(
    parameter int DATA_W    = 8,
    parameter int LOG2_TAPS = 2,    // legal range 1..6
    parameter int ROUND     = 0     // 0 = truncate, 1 = round half up
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              mode,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              primed
);

    localparam int TAPS  = 2 ** LOG2_TAPS;
    // TAPS samples of all-ones fit exactly in DATA_W+LOG2_TAPS bits.
    localparam int SUM_W = DATA_W + LOG2_TAPS;

    localparam logic [LOG2_TAPS:0] TAPS_CNT = (LOG2_TAPS + 1)'(TAPS);
    localparam logic [SUM_W:0]     HALF     = (ROUND != 0) ? (SUM_W + 1)'(TAPS / 2) : '0;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]    hist [TAPS];
    logic [LOG2_TAPS-1:0] wr_ptr;
    logic [SUM_W-1:0]     sum;
    logic [LOG2_TAPS:0]   fill_cnt;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic              accept;
    logic [SUM_W-1:0]  new_sum;
    logic [SUM_W:0]    rnd_sum;
    logic [DATA_W-1:0] avg;
    logic [DATA_W-1:0] result;
    logic              unused_low_bits;

    assign accept = in_valid & ~clear;

    // The oldest entry leaves the window as the new one enters. Entries not
    // yet written since reset/clear are zero, so the pre-prime sum is just the
    // sum of samples seen so far. sum always contains hist[wr_ptr], so the
    // subtraction cannot underflow.
    assign new_sum = sum + SUM_W'(in_data) - SUM_W'(hist[wr_ptr]);

    // One extra bit absorbs the rounding constant before the divide-by-TAPS shift.
    assign rnd_sum = {1'b0, new_sum} + HALF;

    // Arithmetically the shifted value cannot exceed 2**DATA_W-1 (the +TAPS/2
    // only contributes a fractional half), but clamp on the carry bit anyway
    // so the output can never wrap.
    always_comb begin
        avg = rnd_sum[LOG2_TAPS +: DATA_W];
        if (rnd_sum[SUM_W]) begin
            avg = '1;
        end
    end

    assign unused_low_bits = ^rnd_sum[LOG2_TAPS-1:0];

    assign result = mode ? in_data : avg;

    // ------------------------------------------------------------------
    // Sequential update
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            for (int i = 0; i < TAPS; i++) begin
                hist[i] <= '0;
            end
            wr_ptr    <= '0;
            sum       <= '0;
            fill_cnt  <= '0;
            primed    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (clear) begin
            // Flush the window; out_data deliberately keeps its last value.
            for (int i = 0; i < TAPS; i++) begin
                hist[i] <= '0;
            end
            wr_ptr    <= '0;
            sum       <= '0;
            fill_cnt  <= '0;
            primed    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= accept;
            if (accept) begin
                hist[wr_ptr] <= in_data;
                sum          <= new_sum;
                // TAPS is a power of two, so the natural wrap is TAPS-1 -> 0.
                wr_ptr       <= wr_ptr + 1'b1;
                out_data     <= result;
                if (fill_cnt != TAPS_CNT) begin
                    fill_cnt <= fill_cnt + 1'b1;
                end
                if (fill_cnt == TAPS_CNT - 1'b1) begin
                    primed <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/moving_average_fir.md
MOVING_AVERAGE_FIR -- requirements
Module: moving_average_fir

Interface
REQ-001 Parameter DATA_W, default 8: unsigned sample width in bits.
REQ-002 Parameter LOG2_TAPS, default 2: window length TAPS = 2**LOG2_TAPS, legal range 1..6.
REQ-003 Parameter ROUND, default 0: 0 = truncate the average, 1 = round half up.
REQ-004 CLOCK_50  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  reset, synchronous and active-low.
REQ-006 clear  input  1  synchronous flush of the window history, active-high.
REQ-007 mode  input  1  0 = moving average, 1 = bypass (raw sample out).
REQ-008 in_valid  input  1  in_data holds a new sample this cycle.
REQ-009 in_data  input  DATA_W  unsigned input sample.
REQ-010 out_valid  output  1  one-cycle pulse; out_data holds a new result.
REQ-011 out_data  output  DATA_W  filtered or bypassed sample, registered.
REQ-012 primed  output  1  high once TAPS samples have been accepted since the last reset or clear.

Function
REQ-013 History: circular buffer of TAPS words x DATA_W, write pointer wr_ptr of LOG2_TAPS bits, running sum of DATA_W+LOG2_TAPS bits.
REQ-014 Accept: in_valid=1 and clear=0 -> buf[wr_ptr] <= in_data; sum <= sum + in_data - buf[wr_ptr]; wr_ptr <= wr_ptr+1, wrapping from TAPS-1 to 0.
REQ-015 Unwritten buffer entries read as 0, so the sum before priming equals the sum of the samples accepted so far.
REQ-016 Latency: out_valid asserts in the cycle after each accepted sample; out_valid never asserts without an accepted sample.
REQ-017 Average mode: out_data = new_sum >> LOG2_TAPS when ROUND=0, and (new_sum + TAPS/2) >> LOG2_TAPS when ROUND=1; the ROUND=1 addition uses one extra bit, and the result never exceeds 2**DATA_W-1.
REQ-018 Bypass mode: out_data = the accepted in_data; the history and sum still update exactly as in REQ-014.
REQ-019 mode is sampled in the accept cycle; a mode change causes no flush and no extra out_valid pulse.
REQ-020 Fill counter saturates at TAPS; primed <= 1 in the cycle after the TAPS-th accepted sample and stays high until reset or clear.
REQ-021 Back-to-back samples (in_valid high every cycle) are accepted without stalls; throughput is one sample per clock.
REQ-022 out_data holds its last value whenever out_valid=0.
REQ-023 clear=1: buffer entries, sum, wr_ptr, fill counter and primed all go to 0; out_valid <= 0; out_data holds its value.
REQ-024 clear and in_valid in the same cycle: clear wins, the sample is dropped and no out_valid pulse follows.
REQ-025 The sum never overflows: its width is sufficient for TAPS samples of value 2**DATA_W-1.

Reset
REQ-026 reset_n=0 at a clock edge: out_data=0, out_valid=0, primed=0, sum=0, wr_ptr=0, fill counter=0, all buffer entries=0.
REQ-027 Reset overrides clear and in_valid; the sample is dropped, and reset mid-stream discards all history with no pulse after release.
REQ-028 A sample presented in the first edge after reset_n rises is accepted normally.

Verification (DATA_W=8, LOG2_TAPS=2 unless stated)
REQ-029 Reset: hold reset_n=0 for 2 clocks with in_valid=1, in_data=200 -> out_valid=0, out_data=0, primed=0; first post-reset sample 40 -> out_data=10.
REQ-030 Step/fill: four back-to-back samples of 100 -> out_data 25, 50, 75, 100 on consecutive cycles; primed rises with the 4th output.
REQ-031 Wrap: then four samples of 0 -> 75, 50, 25, 0; then 255 x4 with ROUND=1 -> last output 255, no overflow.
REQ-032 Rounding: from clear, sample 2 -> ROUND=0 gives 0, ROUND=1 gives 1; sample 1 -> ROUND=1 gives 0.
REQ-033 Clear collision: primed window of 100s, clear=1 with in_valid=1, in_data=60 -> no pulse, primed=0; next sample 40 -> 10.
REQ-034 Bypass: primed window of 100s, mode=1 with sample 77 -> out_data 77; mode=0 with sample 100 -> out_data 94 (ROUND=0).
